// File: rtl/tl_top_system.sv
// tl_top_system: TileLink-UL loopback subsystem.
// An L1 master adapter converts a start/parameter command into one single-beat
// A-channel request; an L2 slave adapter services it against an internal word
// memory and returns a D-channel response.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start_transaction, transaction_type, address, size, source,
//   write_data, write_mask       command interface (sampled when L1 is idle)
//   transaction_done             one-cycle pulse when the D response is consumed
//   read_data                    data of the last Get response, held
//   mem_write_valid/addr/data/mask, mem_read_valid/addr/data
//                                memory access monitors (valid in the access cycle)
//   resp_valid/opcode/source/data D-channel fire monitor
module tl_top_system #(
  parameter int unsigned TL_ADDR_BITS   = 32,
  parameter int unsigned TL_DATA_BYTES  = 8,
  parameter int unsigned TL_SIZE_BITS   = 3,
  parameter int unsigned TL_SOURCE_BITS = 4,
  parameter int unsigned MEM_AW         = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_transaction,
  input  logic [1:0]                  transaction_type,
  output logic                        transaction_done,
  input  logic [TL_ADDR_BITS-1:0]     address,
  input  logic [TL_SIZE_BITS-1:0]     size,
  input  logic [TL_SOURCE_BITS-1:0]   source,
  input  logic [TL_DATA_BYTES*8-1:0]  write_data,
  input  logic [TL_DATA_BYTES-1:0]    write_mask,
  output logic [TL_DATA_BYTES*8-1:0]  read_data,
  output logic                        mem_write_valid,
  output logic [TL_ADDR_BITS-1:0]     mem_write_addr,
  output logic [TL_DATA_BYTES*8-1:0]  mem_write_data,
  output logic [TL_DATA_BYTES-1:0]    mem_write_mask,
  output logic                        mem_read_valid,
  output logic [TL_ADDR_BITS-1:0]     mem_read_addr,
  output logic [TL_DATA_BYTES*8-1:0]  mem_read_data,
  output logic                        resp_valid,
  output logic [3:0]                  resp_opcode,
  output logic [TL_SOURCE_BITS-1:0]   resp_source,
  output logic [TL_DATA_BYTES*8-1:0]  resp_data
);

  localparam int unsigned DATA_W    = TL_DATA_BYTES * 8;
  localparam int unsigned MEM_WORDS = 1 << MEM_AW;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] D_ACK         = 3'd0;
  localparam logic [2:0] D_ACK_DATA    = 3'd1;

  localparam logic [1:0] L1_IDLE   = 2'd0;
  localparam logic [1:0] L1_A_SEND = 2'd1;
  localparam logic [1:0] L1_D_WAIT = 2'd2;
  localparam logic [1:0] L1_DONE   = 2'd3;

  localparam logic [1:0] L2_IDLE   = 2'd0;
  localparam logic [1:0] L2_ACCESS = 2'd1;
  localparam logic [1:0] L2_RESP   = 2'd2;

  typedef struct packed {
    logic [2:0]                opcode;
    logic [TL_SIZE_BITS-1:0]   size;
    logic [TL_SOURCE_BITS-1:0] source;
    logic [TL_ADDR_BITS-1:0]   address;
    logic [DATA_W-1:0]         data;
    logic [TL_DATA_BYTES-1:0]  mask;
  } a_chan_t;

  typedef struct packed {
    logic [2:0]                opcode;
    logic [TL_SIZE_BITS-1:0]   size;
    logic [TL_SOURCE_BITS-1:0] source;
    logic [DATA_W-1:0]         data;
  } d_chan_t;

  // Channel handshakes (decoded from the adapter state registers)
  logic a_valid, a_ready, d_valid, d_ready;

  // ---------------------------------------------------------------------------
  // L1 master adapter
  // ---------------------------------------------------------------------------
  logic [1:0]        l1_state_q, l1_state_d;
  a_chan_t           a_req_q, a_req_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              resp_match;

  d_chan_t           d_q, d_d;
  logic              d_valid_q, d_valid_d;

  assign d_valid = d_valid_q;

  // Response belongs to the outstanding request (always true with one in flight)
  assign resp_match = (d_q.source == a_req_q.source) && (d_q.size == a_req_q.size);

  // L1 next-state and request latching
  always_comb begin
    l1_state_d  = l1_state_q;
    a_req_d     = a_req_q;
    done_d      = 1'b0;
    read_data_d = read_data_q;
    a_valid     = 1'b0;
    d_ready     = 1'b0;
    case (l1_state_q)
      L1_IDLE: begin
        if (start_transaction && (transaction_type != 2'b11)) begin
          a_req_d.opcode  = (transaction_type == 2'b00) ? A_GET :
                            (transaction_type == 2'b01) ? A_PUT_FULL : A_PUT_PARTIAL;
          a_req_d.size    = size;
          a_req_d.source  = source;
          a_req_d.address = address;
          a_req_d.data    = (transaction_type == 2'b00) ? '0 : write_data;
          a_req_d.mask    = (transaction_type == 2'b10) ? write_mask : '1;
          l1_state_d      = L1_A_SEND;
        end
      end
      L1_A_SEND: begin
        a_valid = 1'b1;
        if (a_ready) l1_state_d = L1_D_WAIT;
      end
      L1_D_WAIT: begin
        d_ready = 1'b1;
        if (d_valid) begin
          if ((a_req_q.opcode == A_GET) && (d_q.opcode == D_ACK_DATA) && resp_match) begin
            read_data_d = d_q.data;
          end
          done_d     = 1'b1;
          l1_state_d = L1_DONE;
        end
      end
      L1_DONE: l1_state_d = L1_IDLE;
      default: l1_state_d = L1_IDLE;
    endcase
  end

  // L1 state register
  always_ff @(posedge clk) begin
    if (rst) begin
      l1_state_q  <= L1_IDLE;
      a_req_q     <= '0;
      done_q      <= 1'b0;
      read_data_q <= '0;
    end else begin
      l1_state_q  <= l1_state_d;
      a_req_q     <= a_req_d;
      done_q      <= done_d;
      read_data_q <= read_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // L2 slave adapter and word memory
  // ---------------------------------------------------------------------------
  logic [1:0]               l2_state_q, l2_state_d;
  a_chan_t                  l2_req_q, l2_req_d;
  logic                     mem_wr_valid_q, mem_wr_valid_d;
  logic [TL_ADDR_BITS-1:0]  mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_W-1:0]        mem_wr_data_q, mem_wr_data_d;
  logic [TL_DATA_BYTES-1:0] mem_wr_mask_q, mem_wr_mask_d;
  logic                     mem_rd_valid_q, mem_rd_valid_d;
  logic [TL_ADDR_BITS-1:0]  mem_rd_addr_q, mem_rd_addr_d;
  logic                     mem_we;
  logic [MEM_AW-1:0]        mem_idx;
  logic [DATA_W-1:0]        mem_rdata;
  logic [DATA_W-1:0]        mem_q [MEM_WORDS];

  // Upper address bits above the word index alias onto the same word
  assign mem_idx   = l2_req_q.address[MEM_AW+2:3];
  assign mem_rdata = mem_q[mem_idx];

  // L2 next-state, access and response generation
  always_comb begin
    l2_state_d     = l2_state_q;
    l2_req_d       = l2_req_q;
    d_d            = d_q;
    d_valid_d      = d_valid_q;
    mem_wr_valid_d = 1'b0;
    mem_wr_addr_d  = '0;
    mem_wr_data_d  = '0;
    mem_wr_mask_d  = '0;
    mem_rd_valid_d = 1'b0;
    mem_rd_addr_d  = '0;
    mem_we         = 1'b0;
    a_ready        = 1'b0;
    case (l2_state_q)
      L2_IDLE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          l2_req_d = a_req_q;
          // Monitors are loaded here so they are valid exactly during ACCESS
          if (a_req_q.opcode == A_GET) begin
            mem_rd_valid_d = 1'b1;
            mem_rd_addr_d  = a_req_q.address;
          end else begin
            mem_wr_valid_d = 1'b1;
            mem_wr_addr_d  = a_req_q.address;
            mem_wr_data_d  = a_req_q.data;
            mem_wr_mask_d  = a_req_q.mask;
          end
          l2_state_d = L2_ACCESS;
        end
      end
      L2_ACCESS: begin
        mem_we      = (l2_req_q.opcode != A_GET);
        d_d.size    = l2_req_q.size;
        d_d.source  = l2_req_q.source;
        d_d.opcode  = (l2_req_q.opcode == A_GET) ? D_ACK_DATA : D_ACK;
        d_d.data    = (l2_req_q.opcode == A_GET) ? mem_rdata : '0;
        d_valid_d   = 1'b1;
        l2_state_d  = L2_RESP;
      end
      L2_RESP: begin
        if (d_ready) begin
          d_valid_d  = 1'b0;
          d_d        = '0;
          l2_state_d = L2_IDLE;
        end
      end
      default: l2_state_d = L2_IDLE;
    endcase
  end

  // L2 state register
  always_ff @(posedge clk) begin
    if (rst) begin
      l2_state_q     <= L2_IDLE;
      l2_req_q       <= '0;
      d_q            <= '0;
      d_valid_q      <= 1'b0;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      mem_wr_mask_q  <= '0;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
    end else begin
      l2_state_q     <= l2_state_d;
      l2_req_q       <= l2_req_d;
      d_q            <= d_d;
      d_valid_q      <= d_valid_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      mem_wr_mask_q  <= mem_wr_mask_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
    end
  end

  // Byte-masked memory write; a reset on the commit edge drops the write
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < int'(TL_DATA_BYTES); b++) begin
        if (l2_req_q.mask[b]) mem_q[mem_idx][b*8 +: 8] <= l2_req_q.data[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign transaction_done = done_q;
  assign read_data        = read_data_q;
  assign mem_write_valid  = mem_wr_valid_q;
  assign mem_write_addr   = mem_wr_addr_q;
  assign mem_write_data   = mem_wr_data_q;
  assign mem_write_mask   = mem_wr_mask_q;
  assign mem_read_valid   = mem_rd_valid_q;
  assign mem_read_addr    = mem_rd_addr_q;
  assign mem_read_data    = mem_rd_valid_q ? mem_rdata : '0;
  assign resp_valid       = d_valid_q & d_ready;
  assign resp_opcode      = 4'(d_q.opcode);
  assign resp_source      = d_q.source;
  assign resp_data        = d_q.data;

endmodule

// File: tb/tb_tl_top_system.sv
// Scoreboard bench for tl_top_system: stimulus pushes expected monitor events
// computed from a word/byte memory model; a negedge monitor pops and compares.
module tb_tl_top_system;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_transaction;
  logic [1:0]  transaction_type;
  logic        transaction_done;
  logic [31:0] address;
  logic [2:0]  size;
  logic [3:0]  source;
  logic [63:0] write_data;
  logic [7:0]  write_mask;
  logic [63:0] read_data;
  logic        mem_write_valid;
  logic [31:0] mem_write_addr;
  logic [63:0] mem_write_data;
  logic [7:0]  mem_write_mask;
  logic        mem_read_valid;
  logic [31:0] mem_read_addr;
  logic [63:0] mem_read_data;
  logic        resp_valid;
  logic [3:0]  resp_opcode;
  logic [3:0]  resp_source;
  logic [63:0] resp_data;

  tl_top_system dut (
    .clk(clk), .rst(rst),
    .start_transaction(start_transaction), .transaction_type(transaction_type),
    .transaction_done(transaction_done), .address(address), .size(size),
    .source(source), .write_data(write_data), .write_mask(write_mask),
    .read_data(read_data),
    .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
    .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .resp_valid(resp_valid), .resp_opcode(resp_opcode),
    .resp_source(resp_source), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  typedef struct { logic [31:0] addr; logic [63:0] data; logic [7:0] mask; } wr_exp_t;
  typedef struct { logic [31:0] addr; logic [63:0] data; logic [63:0] known; } rd_exp_t;
  typedef struct { logic [3:0] opcode; logic [3:0] source; logic [63:0] data; logic [63:0] known; } rsp_exp_t;

  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];
  rsp_exp_t    rsp_q[$];
  int unsigned done_q[$];

  // Reference model: memory words with a per-bit "known" mask
  logic [63:0] mem_m   [int];
  logic [63:0] known_m [int];
  logic [63:0] rd_m     = 64'h0;
  logic [63:0] rd_known = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp,
                       input logic [63:0] known);
    checks++;
    if ((act & known) !== (exp & known)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (bits %h)", name, act, exp, known);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen at cycle %0d with nothing expected", name, cyc);
  endtask

  // Monitor: every valid/done pulse must match the oldest expected event
  always @(negedge clk) begin
    if (armed) begin
      if (mem_write_valid) begin
        if (wr_q.size() == 0) unexpected("mem_write");
        else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("mem_write_addr", 64'(mem_write_addr), 64'(e.addr), '1);
          check("mem_write_data", mem_write_data, e.data, '1);
          check("mem_write_mask", 64'(mem_write_mask), 64'(e.mask), '1);
        end
      end
      if (mem_read_valid) begin
        if (rd_q.size() == 0) unexpected("mem_read");
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("mem_read_addr", 64'(mem_read_addr), 64'(e.addr), '1);
          check("mem_read_data", mem_read_data, e.data, e.known);
        end
      end
      if (resp_valid) begin
        if (rsp_q.size() == 0) unexpected("resp");
        else begin
          rsp_exp_t e;
          e = rsp_q.pop_front();
          check("resp_opcode", 64'(resp_opcode), 64'(e.opcode), '1);
          check("resp_source", 64'(resp_source), 64'(e.source), '1);
          check("resp_data", resp_data, e.data, e.known);
        end
      end
      if (transaction_done) begin
        if (done_q.size() == 0) unexpected("done");
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()), '1);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, " done"}, 64'(transaction_done), 64'h0, '1);
    check({tag, " read_data"}, read_data, 64'h0, '1);
    check({tag, " mem_write"}, 64'({mem_write_valid, mem_write_mask}), 64'h0, '1);
    check({tag, " mem_write_addr"}, 64'(mem_write_addr), 64'h0, '1);
    check({tag, " mem_write_data"}, mem_write_data, 64'h0, '1);
    check({tag, " mem_read"}, 64'({mem_read_valid, mem_read_addr}), 64'h0, '1);
    check({tag, " mem_read_data"}, mem_read_data, 64'h0, '1);
    check({tag, " resp"}, 64'({resp_valid, resp_opcode, resp_source}), 64'h0, '1);
    check({tag, " resp_data"}, resp_data, 64'h0, '1);
  endtask

  // mode 0: normal, 1: extra start pulse during D_WAIT, 2: reset during ACCESS
  task automatic issue(input logic [1:0] ty, input logic [31:0] addr, input logic [2:0] sz,
                       input logic [3:0] src, input logic [63:0] wd, input logic [7:0] wm,
                       input int mode);
    int          idx;
    int unsigned t0;
    bit          got;
    logic [63:0] exp;
    logic [63:0] kn;
    idx = int'(addr[14:3]);
    @(posedge clk); #1;
    start_transaction = 1'b1;
    transaction_type  = ty;
    address = addr; size = sz; source = src; write_data = wd; write_mask = wm;
    t0 = cyc;
    if (!mem_m.exists(idx)) begin
      mem_m[idx]   = 64'h0;
      known_m[idx] = 64'h0;
    end
    case (ty)
      2'b00: begin
        exp = mem_m[idx];
        kn  = known_m[idx];
        rd_q.push_back('{addr, exp, kn});
        if (mode != 2) begin
          rsp_q.push_back('{4'd1, src, exp, kn});
          done_q.push_back(t0 + 4);
          rd_m = exp;
          rd_known = kn;
        end
      end
      2'b01, 2'b10: begin
        for (int b = 0; b < 8; b++) begin
          if (ty == 2'b01 || wm[b]) begin
            mem_m[idx][b*8 +: 8]   = wd[b*8 +: 8];
            known_m[idx][b*8 +: 8] = 8'hFF;
          end
        end
        wr_q.push_back('{addr, wd, (ty == 2'b01) ? 8'hFF : wm});
        if (mode != 2) begin
          rsp_q.push_back('{4'd0, src, 64'h0, '1});
          done_q.push_back(t0 + 4);
        end else begin
          known_m[idx] = 64'h0;
        end
      end
      default: ;
    endcase
    @(posedge clk); #1;
    start_transaction = 1'b0;
    if (mode == 1) begin
      @(posedge clk); #1;
      start_transaction = 1'b1;
      transaction_type  = 2'b00;
      @(posedge clk); #1;
      start_transaction = 1'b0;
    end
    if (mode == 2) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rd_m = 64'h0;
      rd_known = '1;
      @(negedge clk);
      check_outputs_zero("after_abort");
      repeat (6) @(posedge clk);
    end else if (ty == 2'b11) begin
      repeat (6) @(posedge clk);
    end else begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (transaction_done) got = 1'b1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within 20 cycles, expected at cycle %0d", t0 + 4);
      end
      check("read_data", read_data, rd_m, rd_known);
      repeat ((mode == 1) ? 8 : 2) @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    start_transaction = 1'b0;
    transaction_type = 2'b00;
    address = '0; size = '0; source = '0; write_data = '0; write_mask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("idle");

    issue(2'b01, 32'h2000, 3'd3, 4'd2, 64'h11223344AABBCCDD, 8'h00, 0);
    issue(2'b00, 32'h2000, 3'd3, 4'd4, 64'h0, 8'h00, 0);
    check("get_2000_value", read_data, 64'h11223344AABBCCDD, '1);

    issue(2'b01, 32'h3000, 3'd3, 4'd1, 64'h0123456789ABCDEF, 8'h00, 0);
    issue(2'b10, 32'h3000, 3'd3, 4'd5, 64'hFFFFFFFF00000000, 8'hF0, 0);
    issue(2'b00, 32'h3000, 3'd3, 4'd6, 64'h0, 8'h00, 0);
    check("partial_merge_value", read_data, 64'hFFFFFFFF89ABCDEF, '1);

    issue(2'b01, 32'h3008, 3'd3, 4'd7, 64'hCAFEF00DDEADBEEF, 8'h00, 1);
    issue(2'b11, 32'h3008, 3'd3, 4'd8, 64'h5555AAAA5555AAAA, 8'hFF, 0);
    check("put_keeps_read_data", read_data, 64'hFFFFFFFF89ABCDEF, '1);

    issue(2'b01, 32'h1000, 3'd3, 4'd9, 64'h0BADC0DE0BADC0DE, 8'h00, 2);
    issue(2'b00, 32'h2000, 3'd3, 4'd3, 64'h0, 8'h00, 0);
    check("get_after_reset", read_data, 64'h11223344AABBCCDD, '1);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 3) |
           32'($urandom_range(0, 7));
      issue(2'($urandom_range(0, 3)), ra, 3'($urandom_range(0, 3)),
            4'($urandom), {$urandom, $urandom}, 8'($urandom), 0);
    end

    repeat (5) @(posedge clk);
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || rsp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: wr %0d rd %0d rsp %0d done %0d still pending",
               wr_q.size(), rd_q.size(), rsp_q.size(), done_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
